activation_ctrl: RTL and testbench

// Sequencer for the activation datapath (Identity/Relu/Gelu + requant). Latches a per-tile config
// (activation, GELU constants, requant params) and holds it stable for the whole tile.

---
 rtl/activation_ctrl_pkg.sv | 58 +++++
 rtl/activation_ctrl_if.sv | 13 +
 rtl/activation_ctrl_fifo.sv | 75 +++++++
 rtl/activation_ctrl.sv | 185 ++++++++++++++++++
 tb/tb_activation_ctrl.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/activation_ctrl_pkg.sv
// activation_ctrl_pkg: shared types and constants for the
// activation sequencer and the datapath it drives.
package activation_ctrl_pkg;

    localparam int unsigned N           = 4;
    localparam int unsigned WO          = 8;
    localparam int unsigned ACT_LATENCY = 2;
    localparam int unsigned FIFO_DEPTH  = 4;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned FIFO_CNT_W  = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        IDENTITY = 2'd0,
        RELU     = 2'd1,
        GELU     = 2'd2
    } activation_e;

    typedef enum logic {
        RQ_SIGNED   = 1'b0,
        RQ_UNSIGNED = 1'b1
    } requant_mode_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } activation_ctrl_state_e;

    typedef logic signed [WO-1:0] gelu_const_t;
    typedef logic [7:0]           requant_const_t;
    typedef logic signed [7:0]    requant_t;
    typedef logic [N-1:0][WO-1:0] requant_oup_t;

    typedef struct packed {
        activation_e    activation;
        requant_mode_e  requant_mode;
        gelu_const_t    one;
        gelu_const_t    b;
        gelu_const_t    c;
        requant_const_t mult;
        requant_const_t shift;
        requant_t       add;
    } act_cfg_t;

    // Number of vectors currently travelling through the datapath.
    function automatic logic [FIFO_CNT_W-1:0] inflight_cnt(
        input logic [ACT_LATENCY-1:0] pipe
    );
        logic [FIFO_CNT_W-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < ACT_LATENCY; i++) begin
            cnt = cnt + FIFO_CNT_W'(pipe[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/activation_ctrl_if.sv
// activation_ctrl_if: valid/ready vector stream.
// master drives valid/data, slave drives ready.
interface activation_ctrl_if;
    import activation_ctrl_pkg::*;

    logic         valid;
    logic         ready;
    requant_oup_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);

endinterface

// File: rtl/activation_ctrl_fifo.sv
// activation_ctrl_fifo: registered-output FIFO (no fall-through).
// Simultaneous push and pop on a full FIFO keeps the count.
module activation_ctrl_fifo #(
    parameter type         DATA_T = logic,
    parameter int unsigned DEPTH  = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       push_i,
    input  DATA_T                      data_i,
    input  logic                       pop_i,
    output DATA_T                      data_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] usage_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    DATA_T         mem_q [DEPTH];
    DATA_T         mem_d [DEPTH];
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign usage_o = cnt_q;
    assign data_o  = mem_q[rd_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | pop_i);

    // Pointer, count and storage update.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = data_i;
            wr_d        = ptr_inc(wr_q);
        end
        if (do_pop) begin
            rd_d = ptr_inc(rd_q);
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + CW'(1);
        end else if (!do_push && do_pop) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // FIFO state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/activation_ctrl.sv
// activation_ctrl: tile sequencer for the activation datapath.
// Latches tile config, throttles input by FIFO credit, buffers results.
module activation_ctrl
    import activation_ctrl_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    input  logic [CNT_W-1:0]   n_vectors_i,
    input  activation_e        activation_i,
    input  requant_mode_e      requant_mode_i,
    input  gelu_const_t        gelu_one_i,
    input  gelu_const_t        gelu_b_i,
    input  gelu_const_t        gelu_c_i,
    input  requant_const_t     rq_mult_i,
    input  requant_const_t     rq_shift_i,
    input  requant_t           rq_add_i,
    activation_ctrl_if.slave   inp,
    output requant_oup_t       act_data_o,
    output activation_e        act_activation_o,
    output requant_mode_e      act_requant_mode_o,
    output gelu_const_t        act_one_o,
    output gelu_const_t        act_b_o,
    output gelu_const_t        act_c_o,
    output requant_const_t     act_rq_mult_o,
    output requant_const_t     act_rq_shift_o,
    output requant_t           act_rq_add_o,
    output logic               act_calc_en_o,
    output logic               act_calc_en_q_o,
    input  requant_oup_t       act_data_i,
    activation_ctrl_if.master  oup,
    output logic               busy_o,
    output logic               done_o
);

    activation_ctrl_state_e state_q, state_d;
    act_cfg_t               cfg_q, cfg_d;
    logic [CNT_W-1:0]       n_q, n_d;
    logic [CNT_W-1:0]       acc_q, acc_d;
    logic [CNT_W-1:0]       emit_q, emit_d;
    logic [ACT_LATENCY-1:0] pipe_q, pipe_d;

    logic                  start_ok;
    logic                  fire_in;
    logic                  inp_ready;
    logic                  credit_ok;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [FIFO_CNT_W-1:0] fifo_cnt;

    assign start_ok  = (state_q == IDLE) & start_i;
    assign fire_in   = inp.valid & inp_ready;
    assign push      = pipe_q[ACT_LATENCY-1];
    assign pop       = oup.valid & oup.ready;
    assign oup.valid = ~fifo_empty;
    assign inp.ready = inp_ready;
    assign credit_ok = ({1'b0, inflight_cnt(pipe_q)} + {1'b0, fifo_cnt})
                       < (FIFO_CNT_W + 1)'(FIFO_DEPTH);

    assign act_data_o      = inp.data;
    assign act_calc_en_o   = fire_in;
    assign act_calc_en_q_o = pipe_q[0];

    assign act_activation_o   = cfg_q.activation;
    assign act_requant_mode_o = cfg_q.requant_mode;
    assign act_one_o          = cfg_q.one;
    assign act_b_o            = cfg_q.b;
    assign act_c_o            = cfg_q.c;
    assign act_rq_mult_o      = cfg_q.mult;
    assign act_rq_shift_o     = cfg_q.shift;
    assign act_rq_add_o       = cfg_q.add;

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a tile finishes once every accepted vector left.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = (n_vectors_i == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (fire_in && (acc_q == n_q - CNT_W'(1))) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (emit_q == n_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM outputs; input ready never looks at inp.valid.
    always_comb begin
        inp_ready = (state_q == RUN) & (acc_q != n_q) & credit_ok;
        busy_o    = (state_q != IDLE);
        done_o    = (state_q == DONE);
    end

    // Config latch, vector counters and datapath valid pipe.
    always_comb begin
        cfg_d  = cfg_q;
        n_d    = n_q;
        acc_d  = acc_q;
        emit_d = emit_q;
        pipe_d = {pipe_q[ACT_LATENCY-2:0], fire_in};
        if (start_ok) begin
            cfg_d.activation   = activation_i;
            cfg_d.requant_mode = requant_mode_i;
            cfg_d.one          = gelu_one_i;
            cfg_d.b            = gelu_b_i;
            cfg_d.c            = gelu_c_i;
            cfg_d.mult         = rq_mult_i;
            cfg_d.shift        = rq_shift_i;
            cfg_d.add          = rq_add_i;
            n_d                = n_vectors_i;
            acc_d              = '0;
            emit_d             = '0;
        end else begin
            if (fire_in && (acc_q != n_q)) begin
                acc_d = acc_q + CNT_W'(1);
            end
            if (pop && (emit_q != n_q)) begin
                emit_d = emit_q + CNT_W'(1);
            end
        end
    end

    // Sequencer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cfg_q  <= '0;
            n_q    <= '0;
            acc_q  <= '0;
            emit_q <= '0;
            pipe_q <= '0;
        end else begin
            cfg_q  <= cfg_d;
            n_q    <= n_d;
            acc_q  <= acc_d;
            emit_q <= emit_d;
            pipe_q <= pipe_d;
        end
    end

    activation_ctrl_fifo #(
        .DATA_T (requant_oup_t),
        .DEPTH  (FIFO_DEPTH)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .data_i  (act_data_i),
        .pop_i   (pop),
        .data_o  (oup.data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .usage_o (fifo_cnt)
    );

    // Every in-flight vector holds a reserved slot, so a push finds room.
    a_no_push_full : assert property (
        @(posedge clk_i) disable iff (!rst_ni) !(push && fifo_full)
    );

endmodule

// File: tb/tb_activation_ctrl.sv
// tb_activation_ctrl: random tiles against a reference model,
// with a queue scoreboard and a toy two-stage datapath.
module tb_activation_ctrl;
    import activation_ctrl_pkg::*;

    logic             clk_i = 1'b0;
    logic             rst_ni = 1'b0;
    logic             start_i;
    logic [CNT_W-1:0] n_vectors_i;
    act_cfg_t         cfg_in;

    requant_oup_t   act_data_o;
    activation_e    act_activation_o;
    requant_mode_e  act_requant_mode_o;
    gelu_const_t    act_one_o, act_b_o, act_c_o;
    requant_const_t act_rq_mult_o, act_rq_shift_o;
    requant_t       act_rq_add_o;
    logic           act_calc_en_o, act_calc_en_q_o;
    logic           busy_o, done_o;

    requant_oup_t dp_s0, dp_s1;
    act_cfg_t     dp_cfg;
    act_cfg_t     tile_cfg;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int acc_cnt  = 0;
    int out_cnt  = 0;
    int done_cnt = 0;
    int rdy_cnt  = 0;
    int stall_until = 0;
    int ready_pct   = 100;
    int acc_cyc[$];
    int out_cyc[$];
    requant_oup_t exp_q[$];

    always #5 clk_i = ~clk_i;

    activation_ctrl_if inp ();
    activation_ctrl_if oup ();

    activation_ctrl dut (
        .clk_i              (clk_i),
        .rst_ni             (rst_ni),
        .start_i            (start_i),
        .n_vectors_i        (n_vectors_i),
        .activation_i       (cfg_in.activation),
        .requant_mode_i     (cfg_in.requant_mode),
        .gelu_one_i         (cfg_in.one),
        .gelu_b_i           (cfg_in.b),
        .gelu_c_i           (cfg_in.c),
        .rq_mult_i          (cfg_in.mult),
        .rq_shift_i         (cfg_in.shift),
        .rq_add_i           (cfg_in.add),
        .inp                (inp),
        .act_data_o         (act_data_o),
        .act_activation_o   (act_activation_o),
        .act_requant_mode_o (act_requant_mode_o),
        .act_one_o          (act_one_o),
        .act_b_o            (act_b_o),
        .act_c_o            (act_c_o),
        .act_rq_mult_o      (act_rq_mult_o),
        .act_rq_shift_o     (act_rq_shift_o),
        .act_rq_add_o       (act_rq_add_o),
        .act_calc_en_o      (act_calc_en_o),
        .act_calc_en_q_o    (act_calc_en_q_o),
        .act_data_i         (dp_s1),
        .oup                (oup),
        .busy_o             (busy_o),
        .done_o             (done_o)
    );

    // Element-wise activation then requantisation with saturation.
    function automatic requant_oup_t act_fn(input requant_oup_t x,
                                            input act_cfg_t c);
        requant_oup_t y;
        for (int i = 0; i < N; i++) begin
            int v;
            v = int'($signed(x[i]));
            case (c.activation)
                RELU: if (v < 0) v = 0;
                GELU: v = (v < 0) ? ((v * int'(c.one)) >>> 7)
                                  : v + (int'(c.b) >>> 2);
                default: ;
            endcase
            v = ((v * int'(c.mult)) >>> c.shift) + int'(c.add);
            if (c.requant_mode == RQ_UNSIGNED && v < 0) v = 0;
            if (v > 127) v = 127;
            if (v < -128) v = -128;
            y[i] = 8'(v);
        end
        return y;
    endfunction

    function automatic act_cfg_t rand_cfg(input activation_e a);
        act_cfg_t c;
        c.activation   = a;
        c.requant_mode = requant_mode_e'($urandom_range(1));
        c.one          = 8'($urandom_range(255));
        c.b            = 8'($urandom_range(255));
        c.c            = 8'($urandom_range(255));
        c.mult         = 8'($urandom_range(255, 1));
        c.shift        = 8'($urandom_range(7));
        c.add          = 8'($urandom_range(255));
        return c;
    endfunction

    task automatic check(input string nm, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Toy datapath: stage 0 captures input, stage 1 computes result.
    always_comb begin
        dp_cfg.activation   = act_activation_o;
        dp_cfg.requant_mode = act_requant_mode_o;
        dp_cfg.one          = act_one_o;
        dp_cfg.b            = act_b_o;
        dp_cfg.c            = act_c_o;
        dp_cfg.mult         = act_rq_mult_o;
        dp_cfg.shift        = act_rq_shift_o;
        dp_cfg.add          = act_rq_add_o;
    end

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dp_s0 <= '0;
            dp_s1 <= '0;
        end else begin
            if (act_calc_en_o) dp_s0 <= act_data_o;
            if (act_calc_en_q_o) dp_s1 <= act_fn(dp_s0, dp_cfg);
        end
    end

    // Monitor: model pushes on accept, scoreboard pops on emit.
    always @(negedge clk_i) begin
        cyc++;
        if (rst_ni) begin
            if (inp.ready) rdy_cnt++;
            if (done_o) done_cnt++;
            if (inp.valid && inp.ready) begin
                acc_cnt++;
                acc_cyc.push_back(cyc);
                exp_q.push_back(act_fn(inp.data, tile_cfg));
            end
            if (oup.valid && oup.ready) begin
                out_cnt++;
                out_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 64'(oup.data), 64'hx);
                end else begin
                    check("out_data", oup.data, exp_q.pop_front());
                end
            end
        end
    end

    // Downstream ready: optional stall window, then random.
    initial begin
        oup.ready = 1'b0;
        forever begin
            @(posedge clk_i);
            #1;
            oup.ready = (cyc >= stall_until) &&
                        ($urandom_range(99) < ready_pct);
        end
    end

    task automatic run_tile(input int n, input act_cfg_t c,
                            input int vpct, input bit meddle);
        int  sent = 0;
        int  guard = 0;
        bit  meddled = 1'b0;
        n_vectors_i = CNT_W'(n);
        cfg_in      = c;
        tile_cfg    = c;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        while (sent < n && guard < 20000) begin
            inp.valid = ($urandom_range(99) < vpct);
            inp.data  = $urandom;
            if (meddle && !meddled && sent == n / 2) begin
                cfg_in      = rand_cfg(GELU);
                n_vectors_i = CNT_W'(5);
                start_i     = 1'b1;
                meddled     = 1'b1;
            end
            @(negedge clk_i);
            if (inp.valid && inp.ready) sent++;
            @(posedge clk_i);
            #1;
            start_i = 1'b0;
            guard++;
        end
        inp.valid = 1'b0;
        check("tile_inputs_sent", sent, n);
    endtask

    task automatic wait_done(input int budget);
        int k = 0;
        while (!done_o && k < budget) begin
            @(negedge clk_i);
            k++;
        end
        check("done_seen", done_o, 1'b1);
        @(posedge clk_i);
        #1;
    endtask

    task automatic end_tile(input string nm, input int n,
                            input int o0, input int d0);
        repeat (3) @(posedge clk_i);
        #1;
        check({nm, "_outs"}, out_cnt - o0, n);
        check({nm, "_done_once"}, done_cnt - d0, 1);
        check({nm, "_sb_empty"}, exp_q.size(), 0);
        check({nm, "_idle"}, busy_o, 1'b0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        act_cfg_t c;
        int a0, o0, d0, r0, k;
        start_i     = 1'b0;
        n_vectors_i = '0;
        cfg_in      = '0;
        tile_cfg    = '0;
        inp.valid   = 1'b0;
        inp.data    = '0;

        repeat (3) @(negedge clk_i);
        check("rst_busy", busy_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_inp_ready", inp.ready, 1'b0);
        check("rst_oup_valid", oup.valid, 1'b0);
        check("rst_calc_en", act_calc_en_o, 1'b0);
        check("rst_calc_en_q", act_calc_en_q_o, 1'b0);
        check("rst_activation", act_activation_o, IDENTITY);
        check("rst_rq_mult", act_rq_mult_o, 8'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        @(negedge clk_i);
        check("idle_inp_ready", inp.ready, 1'b0);

        // Reset while three vectors are in flight.
        stall_until = cyc + 1000;
        @(posedge clk_i);
        #2;
        a0 = acc_cnt;
        o0 = out_cnt;
        c  = rand_cfg(RELU);
        n_vectors_i = CNT_W'(10);
        cfg_in      = c;
        tile_cfg    = c;
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i   = 1'b0;
        inp.valid = 1'b1;
        k = 0;
        while (acc_cnt - a0 < 3 && k < 50) begin
            inp.data = $urandom;
            @(posedge clk_i);
            #1;
            k++;
        end
        inp.valid = 1'b0;
        check("rst_mid_accepted", acc_cnt - a0, 3);
        rst_ni = 1'b0;
        #1;
        check("rst_mid_busy", busy_o, 1'b0);
        check("rst_mid_oup_valid", oup.valid, 1'b0);
        check("rst_mid_inp_ready", inp.ready, 1'b0);
        exp_q.delete();
        @(posedge clk_i);
        #1;
        rst_ni      = 1'b1;
        stall_until = 0;
        repeat (10) @(posedge clk_i);
        #1;
        check("rst_mid_no_output", out_cnt - o0, 0);
        check("rst_mid_oup_valid_late", oup.valid, 1'b0);

        // Empty tile, and start while in DONE.
        d0 = done_cnt;
        o0 = out_cnt;
        r0 = rdy_cnt;
        run_tile(0, rand_cfg(RELU), 100, 1'b0);
        check("n0_done_now", done_o, 1'b1);
        n_vectors_i = CNT_W'(3);
        start_i     = 1'b1;
        @(posedge clk_i);
        #1;
        start_i = 1'b0;
        check("start_in_done_ignored", busy_o, 1'b0);
        repeat (5) @(posedge clk_i);
        #1;
        check("n0_done_once", done_cnt - d0, 1);
        check("n0_no_outputs", out_cnt - o0, 0);
        check("n0_ready_never", rdy_cnt - r0, 0);

        // Full-throughput GELU tile.
        d0 = done_cnt;
        o0 = out_cnt;
        acc_cyc.delete();
        out_cyc.delete();
        run_tile(64, rand_cfg(GELU), 100, 1'b0);
        wait_done(500);
        if (acc_cyc.size() == 64 && out_cyc.size() == 64) begin
            check("gelu_back_to_back", acc_cyc[63] - acc_cyc[0], 63);
            check("gelu_first_latency", out_cyc[0] - acc_cyc[0],
                  ACT_LATENCY + 1);
        end else begin
            check("gelu_counts", acc_cyc.size() * 1000 + out_cyc.size(),
                  64064);
        end
        end_tile("gelu", 64, o0, d0);

        // RELU tile with downstream stalled for 20 cycles.
        stall_until = cyc + 22;
        @(posedge clk_i);
        #2;
        d0 = done_cnt;
        o0 = out_cnt;
        a0 = acc_cnt;
        fork
            run_tile(16, rand_cfg(RELU), 100, 1'b0);
            begin
                repeat (18) @(negedge clk_i);
                check("stall_accepts", acc_cnt - a0, FIFO_DEPTH);
                check("stall_ready_low", inp.ready, 1'b0);
            end
        join
        wait_done(500);
        end_tile("relu", 16, o0, d0);

        // Config changes and start pulse mid-tile are ignored.
        d0 = done_cnt;
        o0 = out_cnt;
        c  = rand_cfg(IDENTITY);
        run_tile(20, c, 100, 1'b1);
        check("latched_activation", act_activation_o, IDENTITY);
        check("latched_mult", act_rq_mult_o, c.mult);
        check("latched_one", act_one_o, c.one);
        wait_done(500);
        end_tile("ident", 20, o0, d0);

        // Long random tile with random back-pressure.
        ready_pct = 50;
        d0 = done_cnt;
        o0 = out_cnt;
        run_tile(1000, rand_cfg(activation_e'($urandom_range(2))),
                 50, 1'b0);
        wait_done(20000);
        ready_pct = 100;
        end_tile("random", 1000, o0, d0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
